// File: rtl/rx_channel.sv
`default_nettype none
// ============================================================================
// Module      : rx_channel
// Description : HDLC receive bit front end. Samples the serial line, detects
//               flag / abort / idle patterns, removes stuffed zeros and
//               assembles frame contents into bytes (LSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module rx_channel (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_Idle,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_AlignErr
);

    // Oldest bit lives in bit 7, newest in bit 0.
    localparam logic [7:0] C_FLAG      = 8'h7E;  // 0111_1110
    localparam logic [7:0] C_ABORT     = 8'h7F;  // a 0 followed by seven 1s
    localparam logic [7:0] C_IDLE      = 8'hFF;
    // The edge that recognises the flag already shifts out the first flag
    // bit, so seven more flag bits remain to be skipped.
    localparam logic [2:0] C_SKIP_LOAD = 3'd7;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_SKIP = 2'd1,
        S_DATA = 2'd2
    } state_t;

    logic [7:0] r_shiftReg;
    logic [7:0] r_stuffMark;
    logic [2:0] r_onesCnt;
    state_t     r_state;
    state_t     w_stateNext;
    logic [2:0] r_skipCnt;
    logic [2:0] w_skipCntNext;
    logic [2:0] r_bitCnt;
    logic [2:0] w_bitCntNext;
    logic [6:0] r_shadow;
    logic [6:0] w_shadowNext;
    logic [7:0] w_dataNext;
    logic       w_newByte;
    logic       w_alignErr;

    logic w_flagMatch;
    logic w_abortMatch;
    logic w_idleMatch;
    logic w_outBit;
    logic w_outStuffed;
    logic w_rxStuffed;

    assign w_flagMatch  = (r_shiftReg == C_FLAG);
    assign w_abortMatch = (r_shiftReg == C_ABORT);
    assign w_idleMatch  = (r_shiftReg == C_IDLE);
    assign w_outBit     = r_shiftReg[7];
    assign w_outStuffed = r_stuffMark[7];
    // A zero arriving right after exactly five ones was inserted by the sender.
    assign w_rxStuffed  = ~Rx && (r_onesCnt == 3'd5);

    // Bit pipeline: shift register, stuff marks and saturating ones counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_shiftReg  <= 8'h00;
            r_stuffMark <= 8'h00;
            r_onesCnt   <= 3'd0;
        end else if (RxEN) begin
            r_shiftReg  <= {r_shiftReg[6:0], Rx};
            r_stuffMark <= {r_stuffMark[6:0], w_rxStuffed};
            if (!Rx) begin
                r_onesCnt <= 3'd0;
            end else if (r_onesCnt != 3'd7) begin
                r_onesCnt <= r_onesCnt + 3'd1;
            end
        end
    end

    // Frame state machine and byte assembly: next-state and strobe decode.
    always_comb begin
        w_stateNext   = r_state;
        w_skipCntNext = r_skipCnt;
        w_bitCntNext  = r_bitCnt;
        w_shadowNext  = r_shadow;
        w_dataNext    = Rx_Data;
        w_newByte     = 1'b0;
        w_alignErr    = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_flagMatch) begin
                    w_stateNext   = S_SKIP;
                    w_skipCntNext = C_SKIP_LOAD;
                end
            end
            S_SKIP: begin
                if (w_flagMatch) begin
                    w_skipCntNext = C_SKIP_LOAD;
                end else if (w_abortMatch) begin
                    w_stateNext = S_HUNT;
                end else if (r_skipCnt == 3'd1) begin
                    w_stateNext   = S_DATA;
                    w_skipCntNext = 3'd0;
                    w_bitCntNext  = 3'd0;
                end else begin
                    w_skipCntNext = r_skipCnt - 3'd1;
                end
            end
            S_DATA: begin
                // Stuffed zeros are dropped without advancing the bit count.
                if (!w_outStuffed) begin
                    w_bitCntNext = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_newByte  = 1'b1;
                        w_dataNext = {w_outBit, r_shadow};
                    end else begin
                        w_shadowNext[r_bitCnt] = w_outBit;
                    end
                end
                // A closing flag doubles as the next opening flag.
                if (w_flagMatch) begin
                    w_stateNext   = S_SKIP;
                    w_skipCntNext = C_SKIP_LOAD;
                    w_alignErr    = (r_bitCnt != 3'd0) && !w_newByte;
                end else if (w_abortMatch) begin
                    w_stateNext = S_HUNT;
                end
            end
            default: begin
                w_stateNext = S_HUNT;
            end
        endcase
    end

    // State, counters and registered outputs; strobes drop while disabled.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= S_HUNT;
            r_skipCnt      <= 3'd0;
            r_bitCnt       <= 3'd0;
            r_shadow       <= 7'd0;
            Rx_Data        <= 8'h00;
            Rx_NewByte     <= 1'b0;
            Rx_AlignErr    <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_Idle        <= 1'b0;
        end else if (RxEN) begin
            r_state        <= w_stateNext;
            r_skipCnt      <= w_skipCntNext;
            r_bitCnt       <= w_bitCntNext;
            r_shadow       <= w_shadowNext;
            Rx_Data        <= w_dataNext;
            Rx_NewByte     <= w_newByte;
            Rx_AlignErr    <= w_alignErr;
            Rx_FlagDetect  <= w_flagMatch;
            Rx_AbortDetect <= w_abortMatch;
            Rx_Idle        <= w_idleMatch;
        end else begin
            Rx_NewByte     <= 1'b0;
            Rx_AlignErr    <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_channel
// Description : Directed self-checking bench for rx_channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_channel;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RxEN;
    logic       Rx;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_Idle;
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_AlignErr;

    always #5 Clk = ~Clk;

    rx_channel dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .RxEN           (RxEN),
        .Rx             (Rx),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_Idle        (Rx_Idle),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_Data        (Rx_Data),
        .Rx_AlignErr    (Rx_AlignErr)
    );

    int checks = 0;
    int errors = 0;

    // Event log: edge index of each observed pulse (edge k samples bit k).
    int         edgeIdx;
    int         nFlag, nAbort, nIdle, nByte, nAlign;
    int         firstFlag, lastFlag, lastAbort, lastIdle, lastByte, lastAlign;
    logic [7:0] lastData;

    task automatic clearLog();
        edgeIdx = -1;
        nFlag = 0; nAbort = 0; nIdle = 0; nByte = 0; nAlign = 0;
        firstFlag = -1; lastFlag = -1; lastAbort = -1; lastIdle = -1;
        lastByte = -1; lastAlign = -1; lastData = 8'h00;
    endtask

    // Drive one bit, clock it in, and log the registered outputs.
    task automatic tick(input logic b);
        Rx = b;
        @(posedge Clk);
        #1;
        edgeIdx++;
        if (Rx_FlagDetect) begin
            if (nFlag == 0) firstFlag = edgeIdx;
            nFlag++;
            lastFlag = edgeIdx;
        end
        if (Rx_AbortDetect) begin nAbort++; lastAbort = edgeIdx; end
        if (Rx_Idle)        begin nIdle++;  lastIdle  = edgeIdx; end
        if (Rx_NewByte)     begin nByte++;  lastByte  = edgeIdx; lastData = Rx_Data; end
        if (Rx_AlignErr)    begin nAlign++; lastAlign = edgeIdx; end
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tick(v[i]);
    endtask

    task automatic doReset();
        Rst = 1'b1;
        RxEN = 1'b1;
        tick(1'b0);
        tick(1'b0);
        Rst = 1'b0;
        clearLog();
    endtask

    task automatic test_reset();
        Rst = 1'b1; RxEN = 1'b1; Rx = 1'b0;
        tick(1'b0);
        tick(1'b1);
        checks++; if (Rx_FlagDetect !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", Rx_FlagDetect); end
        checks++; if (Rx_AbortDetect !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", Rx_AbortDetect); end
        checks++; if (Rx_Idle !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", Rx_Idle); end
        checks++; if (Rx_NewByte !== 1'b0) begin errors++; $display("FAIL reset_newbyte: got %b expected 0", Rx_NewByte); end
        checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", Rx_Data); end
        checks++; if (Rx_AlignErr !== 1'b0) begin errors++; $display("FAIL reset_alignerr: got %b expected 0", Rx_AlignErr); end
        Rst = 1'b0;
    endtask

    // Nine idle ones (edges 0..8), flag on edges 9..16, then six ones.
    task automatic test_idle_flag();
        doReset();
        for (int i = 0; i < 9; i++) begin
            tick(1'b1);
            if (i == 7) begin
                checks++; if (Rx_Idle !== 1'b0) begin errors++; $display("FAIL idle_early: got %b expected 0", Rx_Idle); end
            end
            if (i == 8) begin
                checks++; if (Rx_Idle !== 1'b1) begin errors++; $display("FAIL idle_level: got %b expected 1", Rx_Idle); end
            end
        end
        sendByte(8'h7E);
        for (int i = 0; i < 6; i++) tick(1'b1);
        checks++; if (firstFlag != 17) begin errors++; $display("FAIL flag_timing: got edge %0d expected 17", firstFlag); end
        checks++; if (nFlag != 1) begin errors++; $display("FAIL flag_width: got %0d high cycles expected 1", nFlag); end
        checks++; if (nByte != 0) begin errors++; $display("FAIL flag_nobyte: got %0d bytes expected 0", nByte); end
    endtask

    // Flag 0..7, 0xA5 on 8..15, flag 16..23.
    task automatic test_byte();
        doReset();
        sendByte(8'h7E);
        sendByte(8'hA5);
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++; if (nByte != 1) begin errors++; $display("FAIL a5_count: got %0d bytes expected 1", nByte); end
        checks++; if (lastData !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", lastData); end
        checks++; if (lastByte != 23) begin errors++; $display("FAIL a5_latency: got edge %0d expected 23", lastByte); end
        checks++; if (nFlag != 2) begin errors++; $display("FAIL a5_flags: got %0d expected 2", nFlag); end
        checks++; if (firstFlag != 8 || lastFlag != 24) begin errors++; $display("FAIL a5_flag_edges: got %0d,%0d expected 8,24", firstFlag, lastFlag); end
        checks++; if (nAlign != 0) begin errors++; $display("FAIL a5_alignerr: got %0d expected 0", nAlign); end
        checks++; if (Rx_Data !== 8'hA5) begin errors++; $display("FAIL a5_hold: got %h expected a5", Rx_Data); end
    endtask

    // Flag 0..7, 1,1,1,1,1,0,1,1,1 on 8..16, flag 17..24.
    task automatic test_stuffed();
        logic [8:0] bits;
        doReset();
        bits = 9'b111011111;
        sendByte(8'h7E);
        for (int i = 0; i < 9; i++) tick(bits[i]);
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++; if (nByte != 1) begin errors++; $display("FAIL stuff_count: got %0d bytes expected 1", nByte); end
        checks++; if (lastData !== 8'hFF) begin errors++; $display("FAIL stuff_data: got %h expected ff", lastData); end
        checks++; if (lastByte != 24) begin errors++; $display("FAIL stuff_latency: got edge %0d expected 24", lastByte); end
        checks++; if (nFlag != 2 || lastFlag != 25) begin errors++; $display("FAIL stuff_flags: got %0d last %0d expected 2 last 25", nFlag, lastFlag); end
        checks++; if (nAlign != 0) begin errors++; $display("FAIL stuff_alignerr: got %0d expected 0", nAlign); end
    endtask

    // Flag 0..7, data 1,0,1,1 on 8..11, abort 12..19, 0x55 20..27, zeros.
    task automatic test_abort();
        logic [3:0] d;
        doReset();
        d = 4'b1101;
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(d[i]);
        tick(1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1);
        sendByte(8'h55);
        for (int i = 0; i < 10; i++) tick(1'b0);
        checks++; if (nAbort != 1 || lastAbort != 20) begin errors++; $display("FAIL abort_timing: got %0d at edge %0d expected 1 at 20", nAbort, lastAbort); end
        checks++; if (nByte != 0) begin errors++; $display("FAIL abort_nobyte: got %0d bytes expected 0", nByte); end
        checks++; if (nAlign != 0) begin errors++; $display("FAIL abort_alignerr: got %0d expected 0", nAlign); end
        checks++; if (nIdle != 1 || lastIdle != 21) begin errors++; $display("FAIL abort_idle: got %0d at edge %0d expected 1 at 21", nIdle, lastIdle); end
        checks++; if (nFlag != 1) begin errors++; $display("FAIL abort_flags: got %0d expected 1", nFlag); end
    endtask

    // Flag 0..7, 0x3C + bits 1,0,0,1 on 8..19, flag 20..27.
    task automatic test_align();
        logic [3:0] d;
        doReset();
        d = 4'b1001;
        sendByte(8'h7E);
        sendByte(8'h3C);
        for (int i = 0; i < 4; i++) tick(d[i]);
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++; if (nByte != 1 || lastData !== 8'h3C) begin errors++; $display("FAIL align_byte: got %0d bytes data %h expected 1 data 3c", nByte, lastData); end
        checks++; if (lastByte != 23) begin errors++; $display("FAIL align_byte_edge: got %0d expected 23", lastByte); end
        checks++; if (nFlag != 2 || lastFlag != 28) begin errors++; $display("FAIL align_flags: got %0d last %0d expected 2 last 28", nFlag, lastFlag); end
        checks++; if (nAlign != 1 || lastAlign != 28) begin errors++; $display("FAIL align_err: got %0d at edge %0d expected 1 at 28", nAlign, lastAlign); end
    endtask

    // Same frame as test_byte with RxEN low on edges 9..13.
    task automatic test_enable_pause();
        logic [7:0] v;
        doReset();
        v = 8'hA5;
        sendByte(8'h7E);
        tick(v[0]);
        RxEN = 1'b0;
        for (int i = 0; i < 5; i++) tick(i[0]);
        checks++; if (Rx_FlagDetect !== 1'b0) begin errors++; $display("FAIL pause_strobe: got %b expected 0", Rx_FlagDetect); end
        RxEN = 1'b1;
        for (int i = 1; i < 8; i++) tick(v[i]);
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++; if (nByte != 1 || lastData !== 8'hA5) begin errors++; $display("FAIL pause_byte: got %0d bytes data %h expected 1 data a5", nByte, lastData); end
        checks++; if (lastByte != 28) begin errors++; $display("FAIL pause_latency: got edge %0d expected 28", lastByte); end
        checks++; if (nFlag != 2 || lastFlag != 29) begin errors++; $display("FAIL pause_flags: got %0d last %0d expected 2 last 29", nFlag, lastFlag); end
        checks++; if (nAlign != 0) begin errors++; $display("FAIL pause_alignerr: got %0d expected 0", nAlign); end
    endtask

    // Complete A5 frame, 4 bits into the next, reset on edge 28, then unframed data.
    task automatic test_reset_midframe();
        logic [3:0] d;
        doReset();
        d = 4'b1101;
        sendByte(8'h7E);
        sendByte(8'hA5);
        sendByte(8'h7E);
        for (int i = 0; i < 4; i++) tick(d[i]);
        checks++; if (Rx_Data !== 8'hA5) begin errors++; $display("FAIL rst_pre_data: got %h expected a5", Rx_Data); end
        Rst = 1'b1;
        tick(1'b1);
        Rst = 1'b0;
        checks++; if ({Rx_FlagDetect, Rx_AbortDetect, Rx_Idle, Rx_NewByte, Rx_AlignErr} !== 5'b0) begin errors++; $display("FAIL rst_mid_strobes: got %b expected 00000", {Rx_FlagDetect, Rx_AbortDetect, Rx_Idle, Rx_NewByte, Rx_AlignErr}); end
        checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", Rx_Data); end
        sendByte(8'h55);
        sendByte(8'hAA);
        for (int i = 0; i < 8; i++) tick(1'b0);
        checks++; if (nByte != 1) begin errors++; $display("FAIL rst_nobyte: got %0d bytes expected 1", nByte); end
        checks++; if (nFlag != 2) begin errors++; $display("FAIL rst_noflag: got %0d flags expected 2", nFlag); end
        checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL rst_post_data: got %h expected 00", Rx_Data); end
    endtask

    initial begin
        Rst = 1'b1;
        RxEN = 1'b1;
        Rx = 1'b0;
        clearLog();
        test_reset();
        test_idle_flag();
        test_byte();
        test_stuffed();
        test_abort();
        test_align();
        test_enable_pause();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
